// File: rtl/prescaler_ctrl.sv
// prescaler_ctrl: bank of CH_NUM prescaler channels, each ticking every div_act clocks,
// configured over a valid/ready command port with tick-aligned (double-buffered) divider updates.
package prescaler_lib;
  localparam int MAX_COUNTER_WIDTH = 32;
endpackage

module prescaler_ctrl #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = prescaler_lib::MAX_COUNTER_WIDTH,
  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_cmd,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [CH_NUM-1:0] tick_o,
  output logic [CH_NUM-1:0] run_o,
  output logic [CH_NUM-1:0] pend_o,
  output logic              err_o
);
  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {CMD_LOAD, CMD_START, CMD_STOP, CMD_LOAD_START} cmd_t;
  state_t             st_q      [CH_NUM];
  logic [CNT_W-1:0]   div_act_q [CH_NUM];
  logic [CNT_W-1:0]   div_shd_q [CH_NUM];
  logic [CNT_W-1:0]   cnt_q     [CH_NUM];
  logic [CH_NUM-1:0]  tick_q, pend_q, term, hit;
  logic               err_q, ch_ok, is_load, is_start, is_stop, reject, acc;
  logic [CNT_W-1:0]   sel_act;
  logic [(1<<CH_W)-1:0] pend_ext;
  always_comb begin
    pend_ext = '0;
    pend_ext[CH_NUM-1:0] = pend_q;
    ch_ok = 32'(cfg_ch) < CH_NUM;
    is_load = (cfg_cmd == CMD_LOAD) || (cfg_cmd == CMD_LOAD_START);
    is_start = (cfg_cmd == CMD_START) || (cfg_cmd == CMD_LOAD_START);
    is_stop = cfg_cmd == CMD_STOP;
    sel_act = '0;
    term = '0;
    run_o = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cfg_ch == CH_W'(i)) sel_act = div_act_q[i];
      term[i] = cnt_q[i] == div_act_q[i] - CNT_W'(1);
      run_o[i] = st_q[i] == RUN;
    end
    // a pending shadow blocks further loads to that channel until it is consumed
    cfg_ready = !(ch_ok && pend_ext[cfg_ch] && is_load);
    reject = !ch_ok || (is_load && cfg_div == '0) || (cfg_cmd == CMD_START && sel_act == '0);
    acc = cfg_valid && cfg_ready;
    hit = '0;
    for (int i = 0; i < CH_NUM; i++) hit[i] = acc && !reject && cfg_ch == CH_W'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        st_q[i]      <= IDLE;
        div_act_q[i] <= '0;
        div_shd_q[i] <= '0;
        cnt_q[i]     <= '0;
      end
      tick_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= acc && reject;
      for (int i = 0; i < CH_NUM; i++) begin
        if (st_q[i] == IDLE) begin
          tick_q[i] <= 1'b0;
          pend_q[i] <= 1'b0;
          if (hit[i] && is_load) begin
            div_act_q[i] <= cfg_div;
            cnt_q[i]     <= '0;
          end
          if (hit[i] && is_start) begin
            st_q[i]  <= RUN;
            cnt_q[i] <= '0;
          end
        end else if (hit[i] && is_stop) begin
          st_q[i]   <= IDLE;
          cnt_q[i]  <= '0;
          pend_q[i] <= 1'b0;
          tick_q[i] <= 1'b0;
        end else begin
          tick_q[i] <= term[i];
          cnt_q[i]  <= term[i] ? '0 : cnt_q[i] + CNT_W'(1);
          if (term[i] && pend_q[i]) begin
            div_act_q[i] <= div_shd_q[i];
            pend_q[i]    <= 1'b0;
          end
          // a load landing on a terminal edge sees the old pend, so it applies one period later
          if (hit[i] && is_load) begin
            div_shd_q[i] <= cfg_div;
            pend_q[i]    <= 1'b1;
          end
        end
      end
    end
  end
  assign tick_o = tick_q;
  assign pend_o = pend_q;
  assign err_o  = err_q;
  for (genvar c = 0; c < CH_NUM; c++) begin : g_chk
    assert property (@(posedge clk) disable iff (!rst_n) st_q[c] != RUN || cnt_q[c] < div_act_q[c]);
  end
endmodule

// File: tb/tb_prescaler_ctrl.sv
// tb_prescaler_ctrl: table vectors, directed corner sequences and a time-based reference model
// that predicts ticks as absolute edge numbers rather than counter values.
module tb_prescaler_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cfg_valid = 1'b0, cfg_ready, err;
  logic [1:0] cfg_ch = '0, cfg_cmd = '0;
  logic [31:0] cfg_div = '0;
  logic [3:0] tick, run, pend;
  prescaler_ctrl #(.CH_NUM(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_cmd(cfg_cmd), .cfg_div(cfg_div), .tick_o(tick), .run_o(run), .pend_o(pend), .err_o(err));

  logic b_valid = 1'b0, b_ready, b_err;
  logic [2:0] b_ch = '0;
  logic [1:0] b_cmd = '0;
  logic [7:0] b_div = '0;
  logic [4:0] b_tick, b_run, b_pend;
  prescaler_ctrl #(.CH_NUM(5), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .cfg_valid(b_valid), .cfg_ready(b_ready), .cfg_ch(b_ch),
    .cfg_cmd(b_cmd), .cfg_div(b_div), .tick_o(b_tick), .run_o(b_run), .pend_o(b_pend), .err_o(b_err));

  logic w_valid = 1'b0, w_ready, w_err;
  logic [0:0] w_ch = '0, w_tick, w_run, w_pend;
  logic [1:0] w_cmd = '0;
  logic [3:0] w_div = '0;
  prescaler_ctrl #(.CH_NUM(1), .CNT_W(4)) u_w (
    .clk(clk), .rst_n(rst_n), .cfg_valid(w_valid), .cfg_ready(w_ready), .cfg_ch(w_ch),
    .cfg_cmd(w_cmd), .cfg_div(w_div), .tick_o(w_tick), .run_o(w_run), .pend_o(w_pend), .err_o(w_err));

  int nchk = 0, nerr = 0;
  bit m_run[4], m_pend[4];
  int unsigned m_act[4], m_shd[4];
  longint m_nxt[4], n = 0;
  logic [3:0] m_tick = '0;
  bit m_err = 1'b0;
  logic rdy_seen;

  typedef struct { int v, ch, cmd, div, tick, run, pend, err; } vec_t;
  vec_t vt[29];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [12:0] mexp();
    logic [3:0] r, p;
    for (int i = 0; i < 4; i++) begin
      r[i] = m_run[i];
      p[i] = m_pend[i];
    end
    return {m_tick, r, p, m_err};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0; m_pend[i] = 0; m_act[i] = 0; m_shd[i] = 0; m_nxt[i] = 0;
    end
    m_tick = '0;
    m_err = 0;
  endtask

  // drive one command on the main DUT, clock once, advance the model; returns at posedge+1
  task automatic step(input int v, input int c, input int m, input int d);
    bit rdy, acc, rej, ld, st;
    cfg_valid = v != 0;
    cfg_ch = 2'(c);
    cfg_cmd = 2'(m);
    cfg_div = 32'(d);
    ld = (m == 0) || (m == 3);
    st = (m == 1) || (m == 3);
    rdy = !(m_pend[c] && ld);
    #1;
    rdy_seen = cfg_ready;
    chk("ready", 32'(cfg_ready), 32'(rdy));
    @(posedge clk);
    n++;
    acc = (v != 0) && rdy;
    rej = ld ? (d == 0) : (m == 1 && m_act[c] == 0);
    m_tick = '0;
    for (int i = 0; i < 4; i++)
      if (m_run[i] && n == m_nxt[i]) begin
        m_tick[i] = 1'b1;
        if (m_pend[i]) begin
          m_act[i] = m_shd[i];
          m_pend[i] = 0;
        end
        m_nxt[i] = n + m_act[i];
      end
    m_err = acc && rej;
    if (acc && !rej) begin
      if (!m_run[c]) begin
        if (ld) m_act[c] = d;
        if (st) begin
          m_run[c] = 1;
          m_nxt[c] = n + m_act[c];
        end
      end else if (m == 2) begin
        m_run[c] = 0;
        m_pend[c] = 0;
        m_tick[c] = 1'b0;
      end else if (ld) begin
        m_shd[c] = d;
        m_pend[c] = 1;
      end
    end
    #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    int t1, t2;
    vt[0] = '{1, 0, 0, 5, 0, 0, 0, 0};
    vt[1] = '{1, 0, 1, 0, 0, 1, 0, 0};
    for (int k = 2; k < 22; k++) vt[k] = '{0, 0, 0, 0, ((k - 1) % 5 == 0) ? 1 : 0, 1, 0, 0};
    vt[22] = '{1, 0, 2, 0, 0, 0, 0, 0};
    vt[23] = '{1, 2, 1, 0, 0, 0, 0, 1};
    vt[24] = '{1, 3, 0, 0, 0, 0, 0, 1};
    vt[25] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vt[26] = '{1, 3, 3, 0, 0, 0, 0, 1};
    vt[27] = '{1, 0, 1, 0, 0, 1, 0, 0};
    vt[28] = '{1, 0, 2, 0, 0, 0, 0, 0};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'({tick, run, pend, err, cfg_ready}), 32'd1);
    #2 rst_n = 1'b1;

    foreach (vt[k]) begin
      step(vt[k].v, vt[k].ch, vt[k].cmd, vt[k].div);
      chk($sformatf("vec%0d_tick", k), 32'(tick), 32'(vt[k].tick));
      chk($sformatf("vec%0d_run", k), 32'(run), 32'(vt[k].run));
      chk($sformatf("vec%0d_pend", k), 32'(pend), 32'(vt[k].pend));
      chk($sformatf("vec%0d_err", k), 32'(err), 32'(vt[k].err));
    end

    step(1, 1, 3, 4);
    chk("shd_run", 32'(run[1]), 32'd1);
    step(0, 0, 0, 0);
    step(1, 1, 0, 7);
    chk("shd_pend", 32'(pend[1]), 32'd1);
    step(1, 1, 0, 9);
    chk("shd_busy", 32'(rdy_seen), 32'd0);
    chk("shd_early", 32'(tick[1]), 32'd0);
    step(0, 0, 0, 0);
    chk("shd_oldtick", 32'(tick[1]), 32'd1);
    chk("shd_clear", 32'(pend[1]), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      step(0, 0, 0, 0);
      chk($sformatf("shd_period7_%0d", k), 32'(tick[1]), 32'(k == 7));
    end

    step(1, 0, 3, 1);
    chk("div1_first", 32'(tick[0]), 32'd0);
    step(0, 0, 0, 0);
    chk("div1_t1", 32'(tick[0]), 32'd1);
    step(0, 0, 0, 0);
    chk("div1_t2", 32'(tick[0]), 32'd1);
    step(1, 0, 2, 0);
    chk("stop_tick", 32'(tick[0]), 32'd0);
    chk("stop_run", 32'(run[0]), 32'd0);

    b_valid = 1'b1; b_ch = 3'd5; b_cmd = 2'd3; b_div = 8'd3;
    step(0, 0, 0, 0);
    chk("oor_ready", 32'(b_ready), 32'd1);
    chk("oor_err", 32'(b_err), 32'd1);
    chk("oor_run", 32'(b_run), 32'd0);
    b_ch = 3'd7; b_cmd = 2'd0;
    step(0, 0, 0, 0);
    chk("oor7_err", 32'(b_err), 32'd1);
    b_valid = 1'b0;
    step(0, 0, 0, 0);
    chk("oor_pulse", 32'(b_err), 32'd0);
    b_valid = 1'b1; b_ch = 3'd4; b_cmd = 2'd3;
    step(0, 0, 0, 0);
    b_valid = 1'b0;
    chk("last_ch_run", 32'(b_run), 32'h10);
    chk("last_ch_err", 32'(b_err), 32'd0);

    w_valid = 1'b1; w_ch = 1'b0; w_cmd = 2'd3; w_div = 4'd15;
    step(0, 0, 0, 0);
    w_valid = 1'b0;
    chk("w_run", 32'(w_run), 32'd1);
    t1 = 0;
    t2 = 0;
    for (int k = 1; k <= 40; k++) begin
      step(0, 0, 0, 0);
      if (w_tick[0]) begin
        if (t1 == 0) t1 = k;
        else if (t2 == 0) t2 = k;
      end
    end
    chk("w_first", 32'(t1), 32'd15);
    chk("w_period", 32'(t2 - t1), 32'd15);
    w_valid = 1'b1; w_ch = 1'b1; w_cmd = 2'd1;
    step(0, 0, 0, 0);
    w_valid = 1'b0;
    chk("w_oor_err", 32'(w_err), 32'd1);

    step(1, 1, 2, 0);
    step(1, 0, 3, 2);
    step(1, 1, 3, 3);
    step(1, 2, 3, 4);
    step(1, 3, 3, 5);
    repeat (3) step(0, 0, 0, 0);
    chk("all_run", 32'(run), 32'hf);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({tick, run, pend, err}), 32'd0);
    chk("async_rst_b", 32'({b_run, w_run}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    step(1, 2, 1, 0);
    chk("post_rst_err", 32'(err), 32'd1);
    chk("post_rst_run", 32'(run), 32'd0);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      chk("model", 32'({tick, run, pend, err}), 32'(mexp()));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
